// File: rtl/multi_issue_ctrl.sv
// multi_issue_ctrl
//   N-way in-order issue controller sitting between the decode FIFO head and
//   the execute lanes. Each cycle it issues the longest prefix of the decoded
//   slots that is free of structural, ordering and data hazards. Multi-cycle
//   results (loads, mul/div, HI/LO) are tracked by a countdown scoreboard.
//
// Optional feature macro: ISSUE_STATS_EN
//   defined   -> stat_* are saturating 32-bit cycle counters
//   undefined -> stat_* are tied to 0, no counter logic
//
// Ports
//   clk, resetn        clock (rising edge) / async active-low reset
//   slot_*             per-slot decoded fields, slot 0 = oldest,
//                      register fields packed 5 bits per slot
//   stall              nothing issues, scoreboard counters freeze
//   flush              nothing issues, scoreboard clears
//   issue_mask         combinational prefix of slots issued this cycle
//   issue_count        popcount of issue_mask
//   sb_pending         registered per-GPR "result outstanding" flags
//   hilo_pending       registered "HI/LO result outstanding" flag
//   stat_full/partial/hazard  issue statistics
module multi_issue_ctrl #(
  parameter int ISSUE_W   = 2,
  parameter int NREG      = 32,
  parameter int LAT_W     = 3,
  parameter int MEM_PORTS = 1
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [ISSUE_W-1:0]             slot_valid,
  input  logic [ISSUE_W*5-1:0]           slot_rs,
  input  logic [ISSUE_W*5-1:0]           slot_rt,
  input  logic [ISSUE_W-1:0]             slot_rs_used,
  input  logic [ISSUE_W-1:0]             slot_rt_used,
  input  logic [ISSUE_W*5-1:0]           slot_dest,
  input  logic [ISSUE_W-1:0]             slot_wb_en,
  input  logic [ISSUE_W*LAT_W-1:0]       slot_lat,
  input  logic [ISSUE_W-1:0]             slot_mem,
  input  logic [ISSUE_W-1:0]             slot_branch,
  input  logic [ISSUE_W-1:0]             slot_priv,
  input  logic [ISSUE_W-1:0]             slot_hilo,
  input  logic                           stall,
  input  logic                           flush,
  output logic [ISSUE_W-1:0]             issue_mask,
  output logic [$clog2(ISSUE_W+1)-1:0]   issue_count,
  output logic [NREG-1:0]                sb_pending,
  output logic                           hilo_pending,
  output logic [31:0]                    stat_full,
  output logic [31:0]                    stat_partial,
  output logic [31:0]                    stat_hazard
);

  localparam int CNT_W = $clog2(ISSUE_W+1);

  logic [LAT_W-1:0] sb_cnt     [NREG];
  logic [LAT_W-1:0] sb_cnt_nxt [NREG];
  logic [LAT_W-1:0] hilo_cnt;
  logic [LAT_W-1:0] hilo_cnt_nxt;

  // Issue selection: walk the slots oldest first; the first slot that fails
  // any check closes the group, so every later slot sees only issued
  // predecessors when it checks intra-group hazards.
  always_comb begin
    logic       go;
    logic       ok;
    logic       hilo_seen;
    logic       priv_seen;
    logic       branch_seen;
    int         mem_seen;
    logic [4:0] rs_k;
    logic [4:0] rt_k;
    logic [4:0] dest_k;
    logic [4:0] dest_j;
    issue_mask  = '0;
    go          = resetn & ~stall & ~flush;
    ok          = 1'b0;
    hilo_seen   = 1'b0;
    priv_seen   = 1'b0;
    branch_seen = 1'b0;
    mem_seen    = 0;
    rs_k        = '0;
    rt_k        = '0;
    dest_k      = '0;
    dest_j      = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      rs_k   = slot_rs[5*k +: 5];
      rt_k   = slot_rt[5*k +: 5];
      dest_k = slot_dest[5*k +: 5];
      ok     = go & slot_valid[k];
      if (slot_rs_used[k] && rs_k != 5'd0 && sb_cnt[rs_k] != '0) ok = 1'b0;
      if (slot_rt_used[k] && rt_k != 5'd0 && sb_cnt[rt_k] != '0) ok = 1'b0;
      for (int j = 0; j < ISSUE_W; j++) begin
        dest_j = slot_dest[5*j +: 5];
        if (j < k && slot_wb_en[j] && dest_j != 5'd0) begin
          if (slot_rs_used[k] && rs_k == dest_j) ok = 1'b0;
          if (slot_rt_used[k] && rt_k == dest_j) ok = 1'b0;
          if (slot_wb_en[k] && dest_k == dest_j) ok = 1'b0;
        end
      end
      if (slot_mem[k] && mem_seen >= MEM_PORTS) ok = 1'b0;
      if (slot_hilo[k] && (hilo_seen || hilo_cnt != '0)) ok = 1'b0;
      if (slot_priv[k] && k != 0) ok = 1'b0;
      // A priv instruction issues alone; a branch terminates the group.
      if (priv_seen || branch_seen) ok = 1'b0;
      issue_mask[k] = ok;
      go            = ok;
      if (slot_mem[k]) mem_seen = mem_seen + 1;
      hilo_seen   = hilo_seen | slot_hilo[k];
      priv_seen   = priv_seen | slot_priv[k];
      branch_seen = branch_seen | slot_branch[k];
    end
  end

  // Popcount of the issued prefix.
  always_comb begin
    issue_count = '0;
    for (int k = 0; k < ISSUE_W; k++)
      issue_count = issue_count + CNT_W'(issue_mask[k]);
  end

  // Next scoreboard state: flush clears, stall holds, otherwise age every
  // outstanding counter and then let newly issued producers overwrite theirs.
  always_comb begin
    for (int r = 0; r < NREG; r++) sb_cnt_nxt[r] = sb_cnt[r];
    hilo_cnt_nxt = hilo_cnt;
    if (flush) begin
      for (int r = 0; r < NREG; r++) sb_cnt_nxt[r] = '0;
      hilo_cnt_nxt = '0;
    end else if (!stall) begin
      for (int r = 0; r < NREG; r++)
        if (sb_cnt[r] != '0) sb_cnt_nxt[r] = sb_cnt[r] - LAT_W'(1);
      if (hilo_cnt != '0) hilo_cnt_nxt = hilo_cnt - LAT_W'(1);
      for (int k = 0; k < ISSUE_W; k++) begin
        if (issue_mask[k] && slot_wb_en[k] && slot_dest[5*k +: 5] != 5'd0 &&
            slot_lat[LAT_W*k +: LAT_W] != '0)
          sb_cnt_nxt[slot_dest[5*k +: 5]] = slot_lat[LAT_W*k +: LAT_W];
        if (issue_mask[k] && slot_hilo[k] && slot_lat[LAT_W*k +: LAT_W] != '0)
          hilo_cnt_nxt = slot_lat[LAT_W*k +: LAT_W];
      end
    end
  end

  // Scoreboard registers; pending flags are registered alongside so they
  // always mirror the counters that will be seen next cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < NREG; r++) sb_cnt[r] <= '0;
      hilo_cnt     <= '0;
      sb_pending   <= '0;
      hilo_pending <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        sb_cnt[r]     <= sb_cnt_nxt[r];
        sb_pending[r] <= (sb_cnt_nxt[r] != '0);
      end
      hilo_cnt     <= hilo_cnt_nxt;
      hilo_pending <= (hilo_cnt_nxt != '0);
    end
  end

`ifdef ISSUE_STATS_EN
  logic [4:0] rs0;
  logic [4:0] rt0;
  logic       hazard0;

  // Slot 0 wants to go but is held back by an outstanding result.
  assign rs0     = slot_rs[4:0];
  assign rt0     = slot_rt[4:0];
  assign hazard0 = slot_valid[0] & ~stall & ~flush &
                   ((slot_rs_used[0] && rs0 != 5'd0 && sb_cnt[rs0] != '0) ||
                    (slot_rt_used[0] && rt0 != 5'd0 && sb_cnt[rt0] != '0) ||
                    (slot_hilo[0] && hilo_cnt != '0));

  // Saturating statistics counters, frozen while a flush is in progress.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_full    <= '0;
      stat_partial <= '0;
      stat_hazard  <= '0;
    end else if (!flush) begin
      if (issue_count == CNT_W'(ISSUE_W) && stat_full != 32'hFFFF_FFFF)
        stat_full <= stat_full + 32'd1;
      if (issue_count != '0 && issue_count != CNT_W'(ISSUE_W) &&
          stat_partial != 32'hFFFF_FFFF)
        stat_partial <= stat_partial + 32'd1;
      if (hazard0 && stat_hazard != 32'hFFFF_FFFF)
        stat_hazard <= stat_hazard + 32'd1;
    end
  end
`else
  assign stat_full    = '0;
  assign stat_partial = '0;
  assign stat_hazard  = '0;
`endif

endmodule

// File: tb/tb_multi_issue_ctrl.sv
// Testbench for multi_issue_ctrl: directed scenarios plus randomized traffic,
// all compared against a behavioural scoreboard model kept in integers.
module tb_multi_issue_ctrl;

  localparam int W  = 2;
  localparam int LW = 3;
  localparam int NR = 32;
  localparam int MP = 1;

  logic            clk = 1'b0;
  logic            resetn;
  logic [W-1:0]    slot_valid, slot_rs_used, slot_rt_used, slot_wb_en;
  logic [W-1:0]    slot_mem, slot_branch, slot_priv, slot_hilo;
  logic [W*5-1:0]  slot_rs, slot_rt, slot_dest;
  logic [W*LW-1:0] slot_lat;
  logic            stall, flush;
  logic [W-1:0]    issue_mask;
  logic [1:0]      issue_count;
  logic [NR-1:0]   sb_pending;
  logic            hilo_pending;
  logic [31:0]     stat_full, stat_partial, stat_hazard;

  // Small 4-wide instance for the branch group-termination case.
  logic [3:0]      v4, br4;
  logic [3:0]      mask4;
  logic [2:0]      count4;
  logic [NR-1:0]   pend4;
  logic            hp4;
  logic [31:0]     sf4, sp4, sh4;

  int    pend [NR];
  int    hilo_pend;
  longint m_full, m_partial, m_hazard;
  int    n_checks = 0;
  int    n_fail   = 0;

  multi_issue_ctrl #(.ISSUE_W(W), .NREG(NR), .LAT_W(LW), .MEM_PORTS(MP)) dut (
    .clk(clk), .resetn(resetn),
    .slot_valid(slot_valid), .slot_rs(slot_rs), .slot_rt(slot_rt),
    .slot_rs_used(slot_rs_used), .slot_rt_used(slot_rt_used),
    .slot_dest(slot_dest), .slot_wb_en(slot_wb_en), .slot_lat(slot_lat),
    .slot_mem(slot_mem), .slot_branch(slot_branch), .slot_priv(slot_priv),
    .slot_hilo(slot_hilo), .stall(stall), .flush(flush),
    .issue_mask(issue_mask), .issue_count(issue_count),
    .sb_pending(sb_pending), .hilo_pending(hilo_pending),
    .stat_full(stat_full), .stat_partial(stat_partial), .stat_hazard(stat_hazard)
  );

  multi_issue_ctrl #(.ISSUE_W(4), .NREG(NR), .LAT_W(LW), .MEM_PORTS(MP)) dut4 (
    .clk(clk), .resetn(resetn),
    .slot_valid(v4), .slot_rs(20'h0), .slot_rt(20'h0),
    .slot_rs_used(4'h0), .slot_rt_used(4'h0),
    .slot_dest(20'h0), .slot_wb_en(4'h0), .slot_lat(12'h0),
    .slot_mem(4'h0), .slot_branch(br4), .slot_priv(4'h0),
    .slot_hilo(4'h0), .stall(1'b0), .flush(1'b0),
    .issue_mask(mask4), .issue_count(count4),
    .sb_pending(pend4), .hilo_pending(hp4),
    .stat_full(sf4), .stat_partial(sp4), .stat_hazard(sh4)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int r = 0; r < NR; r++) pend[r] = 0;
    hilo_pend = 0;
    m_full = 0; m_partial = 0; m_hazard = 0;
  endtask

  // Expected issue group derived from the issue rules using plain integers.
  function automatic logic [W-1:0] modelMask();
    logic [W-1:0] m;
    int mems;
    m = '0;
    mems = 0;
    if (!resetn || stall || flush) return '0;
    for (int k = 0; k < W; k++) begin
      bit ok;
      int rs, rt, dk;
      ok = slot_valid[k];
      rs = int'(slot_rs[5*k +: 5]);
      rt = int'(slot_rt[5*k +: 5]);
      dk = int'(slot_dest[5*k +: 5]);
      if (slot_rs_used[k] && rs != 0 && pend[rs] > 0) ok = 0;
      if (slot_rt_used[k] && rt != 0 && pend[rt] > 0) ok = 0;
      for (int j = 0; j < k; j++) begin
        int dj;
        dj = int'(slot_dest[5*j +: 5]);
        if (slot_wb_en[j] && dj != 0) begin
          if (slot_rs_used[k] && rs == dj) ok = 0;
          if (slot_rt_used[k] && rt == dj) ok = 0;
          if (slot_wb_en[k] && dk == dj) ok = 0;
        end
        if (slot_hilo[j] && slot_hilo[k]) ok = 0;
        if (slot_branch[j] || slot_priv[j]) ok = 0;
      end
      if (slot_mem[k]) mems++;
      if (mems > MP) ok = 0;
      if (slot_hilo[k] && hilo_pend > 0) ok = 0;
      if (slot_priv[k] && k != 0) ok = 0;
      if (!ok) break;
      m[k] = 1'b1;
    end
    return m;
  endfunction

  task automatic clearSlots();
    slot_valid = '0; slot_rs = '0; slot_rt = '0; slot_rs_used = '0; slot_rt_used = '0;
    slot_dest = '0; slot_wb_en = '0; slot_lat = '0; slot_mem = '0;
    slot_branch = '0; slot_priv = '0; slot_hilo = '0;
  endtask

  task automatic setSlot(input int k, input int rs, input bit rsu, input int rt, input bit rtu,
                         input int dest, input bit wb, input int lat, input bit mem,
                         input bit br, input bit pv, input bit hl);
    slot_valid[k] = 1'b1;
    slot_rs[5*k +: 5] = 5'(rs);   slot_rs_used[k] = rsu;
    slot_rt[5*k +: 5] = 5'(rt);   slot_rt_used[k] = rtu;
    slot_dest[5*k +: 5] = 5'(dest); slot_wb_en[k] = wb;
    slot_lat[LW*k +: LW] = LW'(lat);
    slot_mem[k] = mem; slot_branch[k] = br; slot_priv[k] = pv; slot_hilo[k] = hl;
  endtask

  task automatic applyStimulus();
    clearSlots();
    for (int k = 0; k < W; k++) begin
      if ($urandom_range(0, 7) != 0)
        setSlot(k, $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0);
    end
    stall = ($urandom_range(0, 9) == 0);
    flush = ($urandom_range(0, 19) == 0);
  endtask

  task automatic expectMask(input string tag, input logic [W-1:0] val);
    #1;
    checkOutput(tag, 64'(issue_mask), 64'(val));
  endtask

  // One clock: compare at the falling edge, then advance the model at the
  // rising edge using the group the rules say was issued.
  task automatic stepCycle();
    logic [W-1:0]  em;
    logic [NR-1:0] ep;
    int ec;
    bit haz;
    int rs0, rt0;
    @(negedge clk);
    em = modelMask();
    ec = 0;
    for (int k = 0; k < W; k++) ec += int'(em[k]);
    for (int r = 0; r < NR; r++) ep[r] = (pend[r] > 0);
    checkOutput("issue_mask", 64'(issue_mask), 64'(em));
    checkOutput("issue_count", 64'(issue_count), 64'(ec));
    checkOutput("sb_pending", 64'(sb_pending), 64'(ep));
    checkOutput("hilo_pending", 64'(hilo_pending), 64'(hilo_pend > 0));
`ifdef ISSUE_STATS_EN
    checkOutput("stat_full", 64'(stat_full), 64'(m_full));
    checkOutput("stat_partial", 64'(stat_partial), 64'(m_partial));
    checkOutput("stat_hazard", 64'(stat_hazard), 64'(m_hazard));
`else
    checkOutput("stat_zero", 64'(stat_full | stat_partial | stat_hazard), 64'd0);
`endif
    rs0 = int'(slot_rs[4:0]);
    rt0 = int'(slot_rt[4:0]);
    haz = slot_valid[0] && !stall && !flush &&
          ((slot_rs_used[0] && rs0 != 0 && pend[rs0] > 0) ||
           (slot_rt_used[0] && rt0 != 0 && pend[rt0] > 0) ||
           (slot_hilo[0] && hilo_pend > 0));
    @(posedge clk);
    if (resetn) begin
      if (!flush) begin
        if (ec == W) m_full++;
        if (ec > 0 && ec < W) m_partial++;
        if (haz) m_hazard++;
      end
      if (flush) begin
        for (int r = 0; r < NR; r++) pend[r] = 0;
        hilo_pend = 0;
      end else if (!stall) begin
        for (int r = 0; r < NR; r++) if (pend[r] > 0) pend[r]--;
        if (hilo_pend > 0) hilo_pend--;
        for (int k = 0; k < W; k++) begin
          int d, l;
          d = int'(slot_dest[5*k +: 5]);
          l = int'(slot_lat[LW*k +: LW]);
          if (em[k] && slot_wb_en[k] && d != 0 && l != 0) pend[d] = l;
          if (em[k] && slot_hilo[k] && l != 0) hilo_pend = l;
        end
      end
    end
    #1;
  endtask

  initial begin
    modelReset();
    clearSlots();
    stall = 0; flush = 0; resetn = 0;
    v4 = 4'b1111; br4 = 4'b0010;
    setSlot(0, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0);
    #13;
    checkOutput("rst_mask", 64'(issue_mask), 64'd0);
    checkOutput("rst_count", 64'(issue_count), 64'd0);
    checkOutput("rst_pending", 64'(sb_pending), 64'd0);
    @(posedge clk); #1;
    resetn = 1;

    // Independent pair issues together; the 4-wide group stops after the branch.
    clearSlots();
    setSlot(0, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 0);
    setSlot(1, 4, 1, 5, 1, 6, 1, 0, 0, 0, 0, 0);
    expectMask("t1_mask", 2'b11);
    checkOutput("t4_branch_w4", 64'(mask4), 64'b0011);
    stepCycle();
    br4 = 4'b0000;
    #1 checkOutput("t4_nobranch_w4", 64'(mask4), 64'b1111);

    // Intra-group RAW, then the same pair with dest 0.
    clearSlots();
    setSlot(0, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 0);
    setSlot(1, 5, 1, 4, 1, 6, 1, 0, 0, 0, 0, 0);
    expectMask("t2_raw", 2'b01);
    stepCycle();
    slot_dest[4:0] = 5'd0;
    expectMask("t2_dest0", 2'b11);
    stepCycle();

    // Load with lat 2 blocks its consumer for two cycles.
    clearSlots();
    setSlot(0, 1, 1, 0, 0, 8, 1, 2, 1, 0, 0, 0);
    stepCycle();
    clearSlots();
    setSlot(0, 8, 1, 0, 0, 9, 1, 0, 0, 0, 0, 0);
    expectMask("t3_blk1", 2'b00);
    checkOutput("t3_pend8", 64'(sb_pending[8]), 64'd1);
    stepCycle();
    expectMask("t3_blk2", 2'b00);
    stepCycle();
    expectMask("t3_go", 2'b01);
    stepCycle();

    // Structural limits: memory port, privileged slots, branch in slot 0.
    clearSlots();
    setSlot(0, 1, 1, 0, 0, 2, 1, 0, 1, 0, 0, 0);
    setSlot(1, 3, 1, 0, 0, 4, 1, 0, 1, 0, 0, 0);
    expectMask("t4_mem", 2'b01);
    stepCycle();
    slot_mem = '0; slot_priv = 2'b10;
    expectMask("t4_priv1", 2'b01);
    stepCycle();
    slot_priv = 2'b01;
    expectMask("t4_priv0", 2'b01);
    stepCycle();
    slot_priv = 2'b00; slot_branch = 2'b01;
    expectMask("t4_branch0", 2'b01);
    stepCycle();

    // Stall freezes the countdown; flush clears it.
    clearSlots();
    setSlot(0, 1, 1, 0, 0, 9, 1, 4, 0, 0, 0, 0);
    stepCycle();
    clearSlots();
    setSlot(0, 9, 1, 0, 0, 10, 1, 0, 0, 0, 0, 0);
    stall = 1;
    repeat (3) stepCycle();
    stall = 0;
    for (int i = 0; i < 4; i++) begin
      expectMask("t5_wait", 2'b00);
      stepCycle();
    end
    expectMask("t5_go", 2'b01);
    stepCycle();
    clearSlots();
    setSlot(0, 1, 1, 0, 0, 9, 1, 4, 0, 0, 0, 0);
    stepCycle();
    clearSlots();
    setSlot(0, 9, 1, 0, 0, 10, 1, 0, 0, 0, 0, 0);
    flush = 1;
    stepCycle();
    flush = 0;
    #1 checkOutput("t5_flush_pend", 64'(sb_pending), 64'd0);
    expectMask("t5_flush_go", 2'b01);
    stepCycle();

    // Async reset mid-countdown with HI/LO and a GPR outstanding.
    clearSlots();
    setSlot(0, 1, 1, 2, 1, 0, 0, 3, 0, 0, 0, 1);
    setSlot(1, 3, 1, 0, 0, 10, 1, 3, 1, 0, 0, 0);
    stepCycle();
    clearSlots();
    setSlot(0, 10, 1, 0, 0, 11, 1, 0, 0, 0, 0, 0);
    #1 checkOutput("t6_hilo_before", 64'(hilo_pending), 64'd1);
    resetn = 0;
    #1;
    checkOutput("t6_rst_hilo", 64'(hilo_pending), 64'd0);
    checkOutput("t6_rst_pend", 64'(sb_pending), 64'd0);
    checkOutput("t6_rst_mask", 64'(issue_mask), 64'd0);
    modelReset();
    @(posedge clk); #1;
    resetn = 1;
    clearSlots();
    setSlot(0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 1);
    expectMask("t6_mfhi", 2'b01);
    checkOutput("t6_stats", 64'(stat_full | stat_partial | stat_hazard), 64'd0);
    stepCycle();

    for (int i = 0; i < 400; i++) begin
      applyStimulus();
      stepCycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
